uart_rx_deser: RTL and testbench

//   8N1 UART receiver: the receive end of the serial link fed by uart_tx. Synchronises the

---
 rtl/uart_rx_deser.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
//   8N1 UART receiver. The asynchronous RX pin is brought into the clk domain
//   by a two-flop synchroniser. A falling edge on the synchronised line starts
//   a frame. The start bit is re-checked half a bit later, which rejects short
//   glitches. Each data bit and the stop bit are then sampled one full bit
//   period apart, so every sample lands in the middle of its bit. A good stop
//   bit updates rx_data and pulses rx_valid. A low stop bit pulses frame_err,
//   discards the byte, and waits for the line to return high before the
//   receiver re-arms.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   rs232_rx   in   1  asynchronous serial input, idle high
//   rx_data    out  8  last good byte (LSB received first), held until next
//   rx_valid   out  1  one-cycle pulse when rx_data has just been updated
//   frame_err  out  1  one-cycle pulse when the stop bit was sampled low
//   rx_busy    out  1  high while a frame is in progress (any non-IDLE state)
//
// Parameters
//   CLK_HZ / BAUD give DIV, the number of clocks per bit (must be >= 4).
//   HALF = DIV/2 is the delay from the start edge to the start-bit sample.
// -----------------------------------------------------------------------------
module uart_rx_deser #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    // Synchroniser and one extra history flop for falling-edge detection.
    logic r_rx_meta;
    logic r_rx_s;
    logic r_rx_prev;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       w_shift_next;
    logic [7:0]       w_data_next;
    logic             w_valid_next;
    logic             w_ferr_next;

    // Input synchroniser. It resets to the idle level so that leaving
    // reset is never mistaken for a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rs232_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_ferr    <= w_ferr_next;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_data_next    = r_data;
        w_valid_next   = 1'b0;
        w_ferr_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (r_rx_prev && !r_rx_s) begin
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (r_cnt == CNT_HALF_LAST) begin
                    w_cnt_next = '0;
                    if (r_rx_s) begin
                        // The line was high again at mid start bit, so this
                        // was a glitch, not a frame.
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = '0;
                    end
                end
            end

            S_DATA: begin
                if (r_cnt == CNT_BIT_LAST) begin
                    w_cnt_next              = '0;
                    w_shift_next[r_bit_idx] = r_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (r_cnt == CNT_BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = S_WAIT_HI;
                    end
                end
            end

            S_WAIT_HI: begin
                // A break or stuck-low line must not look like a stream of
                // start bits. Re-arm only after the line has gone high.
                w_cnt_next = '0;
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
//   Self-checking bench for uart_rx_deser with CLK_HZ=16, BAUD=1, which gives
//   16 clocks per bit. Frames are generated bit by bit on the line. The
//   expected bytes and strobe cycles come from the frame contents plus a fixed
//   latency: line edge -> 2 synchroniser cycles + HALF + 9 bit periods, plus 1
//   because the line is driven just after a clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_deser;

    localparam int DIV  = 16;
    localparam int HALF = DIV / 2;
    localparam int LAT  = 3 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Observations collected by the monitor.
    int         obs_cyc[$];
    logic [7:0] obs_dat[$];
    int         fe_cyc[$];
    int         busy_cnt = 0;
    int         both_cnt = 0;

    uart_rx_deser #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            obs_cyc.push_back(cyc);
            obs_dat.push_back(rx_data);
            $display("  rx_valid cyc=%0d data=%02h", cyc, rx_data);
        end
        if (frame_err) begin
            fe_cyc.push_back(cyc);
            $display("  frame_err cyc=%0d", cyc);
        end
        if (rx_valid && frame_err) both_cnt++;
        if (rx_busy) busy_cnt++;
    end

    task automatic clear_obs();
        obs_cyc = {};
        obs_dat = {};
        fe_cyc  = {};
        busy_cnt = 0;
    endtask

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame. Must be entered at posedge+1. Returns the cycle
    // at which the start bit was put on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              output int start_cyc);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rs232_rx = bits[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rs232_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
        idle(100);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got=%02h exp=00", rx_data);
        end
        checks++;
        if (obs_dat.size() != 0 || fe_cyc.size() != 0) begin
            errors++; $display("FAIL reset_strobes valid=%0d ferr=%0d exp=0/0", obs_dat.size(), fe_cyc.size());
        end
        checks++;
        if (busy_cnt != 0 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy cycles=%0d now=%b exp=0/0", busy_cnt, rx_busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int s;
        clear_obs();
        send_frame(8'hA5, 1'b1, s);
        idle(10);
        checks++;
        if (obs_dat.size() != 1) begin
            errors++; $display("FAIL single_count got=%0d exp=1", obs_dat.size());
        end else begin
            checks++;
            if (obs_dat[0] !== 8'hA5) begin
                errors++; $display("FAIL single_data got=%02h exp=a5", obs_dat[0]);
            end
            checks++;
            if (obs_cyc[0] != s + LAT) begin
                errors++; $display("FAIL single_latency got=%0d exp=%0d", obs_cyc[0] - s, LAT);
            end
        end
        checks++;
        if (fe_cyc.size() != 0) begin
            errors++; $display("FAIL single_ferr got=%0d exp=0", fe_cyc.size());
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL single_busy_end got=%b exp=0", rx_busy);
        end
        $display("test_single A5 done");
    endtask

    task automatic test_back_to_back();
        int s0, s1;
        clear_obs();
        send_frame(8'h00, 1'b1, s0);
        send_frame(8'hFF, 1'b1, s1);
        idle(10);
        checks++;
        if (obs_dat.size() != 2) begin
            errors++; $display("FAIL b2b_count got=%0d exp=2", obs_dat.size());
        end else begin
            checks++;
            if (obs_dat[0] !== 8'h00 || obs_dat[1] !== 8'hFF) begin
                errors++; $display("FAIL b2b_data got=%02h,%02h exp=00,ff", obs_dat[0], obs_dat[1]);
            end
            checks++;
            if (obs_cyc[1] - obs_cyc[0] != DIV * 10) begin
                errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", obs_cyc[1] - obs_cyc[0], DIV * 10);
            end
            checks++;
            if (obs_cyc[0] != s0 + LAT) begin
                errors++; $display("FAIL b2b_latency got=%0d exp=%0d", obs_cyc[0] - s0, LAT);
            end
        end
        checks++;
        if (fe_cyc.size() != 0) begin
            errors++; $display("FAIL b2b_ferr got=%0d exp=0", fe_cyc.size());
        end
        $display("test_back_to_back 00,FF done");
    endtask

    task automatic test_glitch();
        clear_obs();
        rs232_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        checks++;
        if (busy_cnt != HALF) begin
            errors++; $display("FAIL glitch_busy_cycles got=%0d exp=%0d", busy_cnt, HALF);
        end
        checks++;
        if (obs_dat.size() != 0 || fe_cyc.size() != 0) begin
            errors++; $display("FAIL glitch_strobes valid=%0d ferr=%0d exp=0/0", obs_dat.size(), fe_cyc.size());
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy_end got=%b exp=0", rx_busy);
        end
        $display("test_glitch done");
    endtask

    task automatic test_frame_err();
        int s, s2;
        logic [7:0] prev;
        prev = 8'hFF;
        clear_obs();
        send_frame(8'h3C, 1'b0, s);
        rs232_rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++; $display("FAIL ferr_stuck_busy got=%b exp=1", rx_busy);
        end
        idle(DIV);
        checks++;
        if (fe_cyc.size() != 1) begin
            errors++; $display("FAIL ferr_count got=%0d exp=1", fe_cyc.size());
        end else begin
            checks++;
            if (fe_cyc[0] != s + LAT) begin
                errors++; $display("FAIL ferr_latency got=%0d exp=%0d", fe_cyc[0] - s, LAT);
            end
        end
        checks++;
        if (obs_dat.size() != 0 || rx_data !== prev) begin
            errors++; $display("FAIL ferr_data_kept valid=%0d data=%02h exp=0/%02h", obs_dat.size(), rx_data, prev);
        end
        send_frame(8'h81, 1'b1, s2);
        idle(10);
        checks++;
        if (obs_dat.size() != 1) begin
            errors++; $display("FAIL ferr_recover_count got=%0d exp=1", obs_dat.size());
        end else begin
            checks++;
            if (obs_dat[0] !== 8'h81 || obs_cyc[0] != s2 + LAT) begin
                errors++; $display("FAIL ferr_recover got=%02h@%0d exp=81@%0d", obs_dat[0], obs_cyc[0] - s2, LAT);
            end
        end
        $display("test_frame_err 3C/81 done");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int s;
        b = 8'h55;
        clear_obs();
        rs232_rx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rs232_rx = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rs232_rx = b[4];
        repeat (HALF) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(200);
        checks++;
        if (obs_dat.size() != 0 || fe_cyc.size() != 0) begin
            errors++; $display("FAIL rstmid_strobes valid=%0d ferr=%0d exp=0/0", obs_dat.size(), fe_cyc.size());
        end
        checks++;
        if (rx_data !== 8'h00 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_state data=%02h busy=%b exp=00/0", rx_data, rx_busy);
        end
        send_frame(8'h12, 1'b1, s);
        idle(10);
        checks++;
        if (obs_dat.size() != 1) begin
            errors++; $display("FAIL rstmid_next_count got=%0d exp=1", obs_dat.size());
        end else begin
            checks++;
            if (obs_dat[0] !== 8'h12 || rx_data !== 8'h12) begin
                errors++; $display("FAIL rstmid_next_data got=%02h exp=12", obs_dat[0]);
            end
        end
        $display("test_reset_midframe done");
    endtask

    task automatic test_random();
        int         exp_cyc[$];
        logic [7:0] exp_dat[$];
        int s, gap;
        logic [7:0] b;
        clear_obs();
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom_range(0, 255));
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            send_frame(b, 1'b1, s);
            exp_cyc.push_back(s + LAT);
            exp_dat.push_back(b);
            $display("  sent %02h start=%0d gap=%0d", b, s, gap);
            idle(gap);
        end
        idle(10);
        checks++;
        if (obs_dat.size() != exp_dat.size()) begin
            errors++; $display("FAIL rand_count got=%0d exp=%0d", obs_dat.size(), exp_dat.size());
        end else begin
            for (int i = 0; i < exp_dat.size(); i++) begin
                checks++;
                if (obs_dat[i] !== exp_dat[i] || obs_cyc[i] != exp_cyc[i]) begin
                    errors++;
                    $display("FAIL rand_frame%0d got=%02h@%0d exp=%02h@%0d", i, obs_dat[i], obs_cyc[i], exp_dat[i], exp_cyc[i]);
                end
            end
        end
        checks++;
        if (fe_cyc.size() != 0) begin
            errors++; $display("FAIL rand_ferr got=%0d exp=0", fe_cyc.size());
        end
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL valid_ferr_overlap got=%0d exp=0", both_cnt);
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
